// File: rtl/risc_pkg.sv
// Shared types for the data-memory port arbiter: bus widths, FSM states and
// the owner encoding for whichever requester holds the memory.
package risc_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select between the CPU and debug requesters. Ties go to the CPU unless
// DMEM_ARB_RR_EN is defined, which alternates ties using a registered pointer.
module dmem_arb_pick
    import risc_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic   clk,
    input  logic   reset,
    input  logic   grant,
`endif
    input  logic   cpu_req,
    input  logic   dbg_req,
    output owner_t winner
);

`ifdef DMEM_ARB_RR_EN
    // last_cpu=1 means the CPU holds the last grant; the reset value of 0
    // therefore hands the first tie to the CPU.
    logic last_cpu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_cpu <= 1'b0;
        end else if (grant) begin
            last_cpu <= (winner == OWN_CPU);
        end
    end

    always_comb begin
        winner = OWN_CPU;
        if (dbg_req && (!cpu_req || last_cpu)) winner = OWN_DBG;
    end
`else
    always_comb begin
        winner = (dbg_req && !cpu_req) ? OWN_DBG : OWN_CPU;
    end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises CPU load/store and debug reads onto the single-port dmem, one
// transaction at a time. Tie policy is selected by DMEM_ARB_RR_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W  = risc_pkg::ADDR_W,
    parameter int DATA_W  = risc_pkg::DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    import risc_pkg::*;

    localparam int CNT_W = 2;

    arb_state_t       state, state_nxt;
    owner_t           owner, winner;
    logic             we_l;
    logic             grant;
    logic [CNT_W-1:0] cnt;

    assign grant = (state == IDLE) && (cpu_req || dbg_req);

    dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk     (clk),
        .reset   (reset),
        .grant   (grant),
`endif
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req || dbg_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_l ? ACK : WAIT;
            WAIT:    if (cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up
    // exactly with the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_CPU;
            we_l      <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            mem_en  <= grant;
            mem_we  <= grant && (winner == OWN_CPU) && cpu_we;
            busy    <= (state_nxt != IDLE);
            cpu_ack <= (state_nxt == ACK) && (owner == OWN_CPU);
            dbg_ack <= (state_nxt == ACK) && (owner == OWN_DBG);

            if (grant) begin
                owner     <= winner;
                we_l      <= (winner == OWN_CPU) && cpu_we;
                mem_addr  <= (winner == OWN_CPU) ? cpu_addr : dbg_addr;
                mem_wdata <= (winner == OWN_CPU) ? cpu_wdata : '0;
            end

            if (state == ISSUE) begin
                cnt <= CNT_W'(MEM_LAT - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            if (state == WAIT && cnt == '0) begin
                if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
                else                  dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule
